// File: rtl/ad9781_spi_cfg_ctrl.sv
// ad9781_spi_cfg_ctrl
// Walks the AD9781 register look-up table and shifts each 24-bit entry
// ({16-bit address, 8-bit data}) to the DAC over 3-wire SPI (mode 0, MSB
// first), one chip-select frame per entry. Runs once after reset plus a
// power-up delay, and again on every start pulse seen in IDLE.
//
// Ports
//   clk        system clock
//   rst        synchronous active-high reset
//   start      one-cycle request to re-send the whole table (IDLE only)
//   lut_index  table address driven to the LUT, stable for a whole frame
//   lut_data   LUT entry at lut_index (combinational); 24'hFFFFFF ends the table
//   spi_csn    chip select, active low
//   spi_sclk   serial clock, idle low
//   spi_sdio   serial data, changes only at CSN fall or SCLK fall
//   busy       high while a pass is in progress
//   done       level, set after a complete pass, cleared when a new pass starts
//
// state    | meaning
// PWR_WAIT | power-up delay after reset, start ignored
// IDLE     | table sent, waiting for start
// LOAD     | capture lut_data, drop CSN and present bit 23
// SHIFT    | 24 SCLK periods, data shifted out on falling edges
// HOLD     | CSN held low one half-period after the last falling edge
// GAP      | CSN high between frames, then next index or finish
// FINISH   | flag done, return index to 0
module ad9781_spi_cfg_ctrl #(
    parameter int LUT_NUM = 10,
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 8,
    parameter int PWR_DLY = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [9:0]  lut_index,
    input  logic [23:0] lut_data,
    output logic        spi_csn,
    output logic        spi_sclk,
    output logic        spi_sdio,
    output logic        busy,
    output logic        done
);

    // One shared cycle counter serves the power-up delay, the SCLK divider,
    // the hold time and the inter-frame gap, so it is sized for the largest.
    localparam int MAX_A   = (PWR_DLY > CLK_DIV) ? PWR_DLY : CLK_DIV;
    localparam int CNT_MAX = (MAX_A > CS_GAP) ? MAX_A : CS_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(PWR_DLY - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(CS_GAP - 1);
    localparam logic [9:0]       IDX_LAST = 10'(LUT_NUM - 1);

    typedef enum logic [2:0] {
        PWR_WAIT,
        IDLE,
        LOAD,
        SHIFT,
        HOLD,
        GAP,
        FINISH
    } state_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [4:0]       bit_cnt, bit_cnt_d;
    logic [23:0]      sr, sr_d;
    logic [9:0]       lut_index_d;
    logic             csn_d, sclk_d, sdio_d, busy_d, done_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= PWR_WAIT;
            cnt       <= '0;
            bit_cnt   <= '0;
            sr        <= '0;
            lut_index <= '0;
            spi_csn   <= 1'b1;
            spi_sclk  <= 1'b0;
            spi_sdio  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            bit_cnt   <= bit_cnt_d;
            sr        <= sr_d;
            lut_index <= lut_index_d;
            spi_csn   <= csn_d;
            spi_sclk  <= sclk_d;
            spi_sdio  <= sdio_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        bit_cnt_d   = bit_cnt;
        sr_d        = sr;
        lut_index_d = lut_index;
        csn_d       = spi_csn;
        sclk_d      = spi_sclk;
        sdio_d      = spi_sdio;
        busy_d      = busy;
        done_d      = done;

        case (state)
            PWR_WAIT: begin
                if (cnt == PWR_LAST) begin
                    cnt_d       = '0;
                    lut_index_d = '0;
                    busy_d      = 1'b1;
                    state_d     = LOAD;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            IDLE: begin
                if (start) begin
                    lut_index_d = '0;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    state_d     = LOAD;
                end
            end
            LOAD: begin
                sr_d = lut_data;
                if (lut_data == 24'hFFFFFF) begin
                    state_d = FINISH;
                end else begin
                    csn_d     = 1'b0;
                    sdio_d    = lut_data[23];
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == DIV_LAST) begin
                    cnt_d = '0;
                    if (!spi_sclk) begin
                        sclk_d = 1'b1;
                    end else begin
                        // Rotate so the next bit sits at [23]; present it now
                        // so it is stable a full half-period before the rise.
                        sclk_d = 1'b0;
                        sr_d   = {sr[22:0], sr[23]};
                        sdio_d = sr[22];
                        if (bit_cnt == 5'd23) begin
                            state_d = HOLD;
                        end else begin
                            bit_cnt_d = bit_cnt + 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            HOLD: begin
                if (cnt == DIV_LAST) begin
                    cnt_d   = '0;
                    csn_d   = 1'b1;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_d = '0;
                    if (lut_index == IDX_LAST) begin
                        state_d = FINISH;
                    end else begin
                        lut_index_d = lut_index + 1'b1;
                        state_d     = LOAD;
                    end
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            FINISH: begin
                done_d      = 1'b1;
                busy_d      = 1'b0;
                lut_index_d = '0;
                state_d     = IDLE;
            end
            default: begin
                state_d = PWR_WAIT;
            end
        endcase
    end

endmodule
